// File: rtl/odd_parity_pkg.sv
// Shared types and line-level constants for the odd-parity serial link.
package odd_parity_pkg;

    // Transmitter frame phases, in line order.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage : odd_parity_pkg

// File: rtl/odd_parity_gen.sv
// Combinational odd-parity generator: the returned bit makes the total
// count of ones across data and parity odd (all-zero data gives 1).
module odd_parity_gen #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data_i,
    output logic              par_o
);

    // Parity bit is the inverted XOR reduction of the word.
    always_comb begin
        par_o = ~(^data_i);
    end

endmodule : odd_parity_gen

// File: rtl/odd_parity_serial_tx.sv
// Odd-parity serial frame transmitter: start(0), DATA_W bits LSB-first,
// odd parity, stop(1). Each bit is held CLKS_PER_BIT cycles. The line and
// status outputs are registered from the next-state values so that an
// accept at edge k drives the start bit from that same edge.
module odd_parity_serial_tx
    import odd_parity_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              tx_serial,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W + 1) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [BAUD_W-1:0] BAUD_ZERO = {BAUD_W{1'b0}};
    localparam logic [BIT_W-1:0]  BIT_ZERO  = {BIT_W{1'b0}};

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              serial_q, serial_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              par_s;
    logic              baud_wrap_s;

    odd_parity_gen #(
        .DATA_W (DATA_W)
    ) u_par_gen (
        .data_i (tx_data),
        .par_o  (par_s)
    );

    // Next-state logic: phase sequencing, baud/bit counting, data shifting.
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        par_d       = par_q;
        baud_wrap_s = (baud_q == BAUD_LAST);
        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d = START;
                    baud_d  = BAUD_ZERO;
                    bit_d   = BIT_ZERO;
                    shift_d = tx_data;
                    par_d   = par_s;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (baud_wrap_s) begin
                    state_d = DATA;
                    baud_d  = BAUD_ZERO;
                end else begin
                    baud_d  = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_wrap_s) begin
                    baud_d  = BAUD_ZERO;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        state_d = PARITY;
                        bit_d   = BIT_ZERO;
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d  = baud_q + BAUD_W'(1);
                end
            end
            PARITY: begin
                if (baud_wrap_s) begin
                    state_d = STOP;
                    baud_d  = BAUD_ZERO;
                end else begin
                    baud_d  = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_wrap_s) begin
                    state_d = IDLE;
                    baud_d  = BAUD_ZERO;
                end else begin
                    baud_d  = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = BAUD_ZERO;
                bit_d   = BIT_ZERO;
            end
        endcase
    end

    // Output decode from the upcoming state so every output is a flop.
    always_comb begin
        serial_d = LINE_IDLE;
        case (state_d)
            IDLE:    serial_d = LINE_IDLE;
            START:   serial_d = START_BIT;
            DATA:    serial_d = shift_d[0];
            PARITY:  serial_d = par_d;
            STOP:    serial_d = STOP_BIT;
            default: serial_d = LINE_IDLE;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == STOP) && (baud_d == BAUD_LAST);
    end

    // State, counters and registered outputs; reset parks the line high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= BAUD_ZERO;
            bit_q    <= BIT_ZERO;
            shift_q  <= {DATA_W{1'b0}};
            par_q    <= 1'b0;
            serial_q <= LINE_IDLE;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            serial_q <= serial_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign tx_serial = serial_q;
    assign tx_ready  = ready_q;
    assign tx_busy   = busy_q;
    assign tx_done   = done_q;

endmodule : odd_parity_serial_tx

// File: tb/tb_odd_parity_serial_tx.sv
// Bench for odd_parity_serial_tx: one instance at 4 clocks/bit, one at
// 1 clock/bit. Expected frames are queued when a word is handed over and
// popped by the frame checker, which also runs a receive-side parity check.
module tb_odd_parity_serial_tx;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       tx_valid_a = 1'b0;
    logic [7:0] tx_data_a  = 8'h00;
    logic       ready_a, ser_a, busy_a, done_a;
    logic       tx_valid_b = 1'b0;
    logic [7:0] tx_data_b  = 8'h00;
    logic       ready_b, ser_b, busy_b, done_b;

    logic mon_sel = 1'b0;
    logic mon_line, mon_ready, mon_busy, mon_done;

    int   n_cmp = 0;
    int   n_err = 0;
    vec_t sb_q[$];
    vec_t vecs[8];

    odd_parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .rst(rst), .tx_valid(tx_valid_a), .tx_data(tx_data_a),
        .tx_ready(ready_a), .tx_serial(ser_a), .tx_busy(busy_a), .tx_done(done_a)
    );

    odd_parity_serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut_b (
        .clk(clk), .rst(rst), .tx_valid(tx_valid_b), .tx_data(tx_data_b),
        .tx_ready(ready_b), .tx_serial(ser_b), .tx_busy(busy_b), .tx_done(done_b)
    );

    always #5 clk = ~clk;

    always_comb begin
        mon_line  = mon_sel ? ser_b   : ser_a;
        mon_ready = mon_sel ? ready_b : ready_a;
        mon_busy  = mon_sel ? busy_b  : busy_a;
        mon_done  = mon_sel ? done_b  : done_a;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present a word at the current negedge; queue it once ready is seen.
    task automatic send(input logic sel, input vec_t v);
        bit ok = 1'b0;
        mon_sel = sel;
        if (sel) begin tx_valid_b = 1'b1; tx_data_b = v.data; end
        else     begin tx_valid_a = 1'b1; tx_data_a = v.data; end
        for (int t = 0; t < 100; t++) begin
            if (mon_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) sb_q.push_back(v);
        else    chk("accept_timeout", 32'd0, 32'd1);
    endtask

    // Idle-cycle checks between frames.
    task automatic chk_idle(input string name);
        chk({name, "_line"},  {31'd0, mon_line},  32'd1);
        chk({name, "_ready"}, {31'd0, mon_ready}, 32'd1);
        chk({name, "_busy"},  {31'd0, mon_busy},  32'd0);
        chk({name, "_done"},  {31'd0, mon_done},  32'd0);
    endtask

    // Follow one frame cycle by cycle starting at the cycle after accept.
    task automatic check_frame(input logic sel, input bit hold, input bit perturb,
                               input int abort_at);
        vec_t        f;
        int          cpb = sel ? 1 : 4;
        int          len = 11 * cpb;
        int          b;
        logic [10:0] exp_line;
        logic [7:0]  rx_d = 8'h00;
        logic        rx_p = 1'b0;
        bit          line_ok = 1'b1, br_ok = 1'b1, done_ok = 1'b1;
        int          bad_c = -1;
        int          ones;
        mon_sel = sel;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
            return;
        end
        f = sb_q.pop_front();
        exp_line = {1'b1, f.par, f.data, 1'b0};
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            if (c == 0 && !hold) begin
                if (sel) tx_valid_b = 1'b0;
                else     tx_valid_a = 1'b0;
            end
            if (c == abort_at) begin
                rst = 1'b1;
                #1;
                chk("rst_line",  {31'd0, mon_line},  32'd1);
                chk("rst_busy",  {31'd0, mon_busy},  32'd0);
                chk("rst_ready", {31'd0, mon_ready}, 32'd1);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            b = c / cpb;
            if (mon_line !== exp_line[b]) begin
                if (line_ok) bad_c = c;
                line_ok = 1'b0;
            end
            if (mon_busy !== 1'b1 || mon_ready !== 1'b0) br_ok = 1'b0;
            if (mon_done !== (c == len - 1)) done_ok = 1'b0;
            if ((c % cpb) == (cpb / 2)) begin
                if (b >= 1 && b <= 8) rx_d[b-1] = mon_line;
                if (b == 9) rx_p = mon_line;
            end
            if (perturb && !sel) begin
                if (c == 12) begin tx_valid_a = 1'b1; tx_data_a = ~f.data; end
                if (c == 40) tx_valid_a = 1'b0;
            end
        end
        if (!line_ok) $display("FAIL frame_line: data %0h first wrong cycle %0d", f.data, bad_c);
        chk("frame_line", {31'd0, line_ok}, 32'd1);
        chk("frame_busy_ready", {31'd0, br_ok}, 32'd1);
        chk("frame_done", {31'd0, done_ok}, 32'd1);
        chk("rx_data", {24'd0, rx_d}, {24'd0, f.data});
        chk("rx_par", {31'd0, rx_p}, {31'd0, f.par});
        ones = $countones({rx_d, rx_p});
        chk("rx_odd_ones", ones % 2, 32'd1);
    endtask

    initial begin
        bit quiet_ok;
        vecs[0] = '{8'h00, 1'b1};
        vecs[1] = '{8'h01, 1'b0};
        vecs[2] = '{8'h07, 1'b0};
        vecs[3] = '{8'hA5, 1'b1};
        vecs[4] = '{8'hFF, 1'b1};
        vecs[5] = '{8'h3C, 1'b1};
        vecs[6] = '{8'h55, 1'b1};
        vecs[7] = '{8'h80, 1'b0};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        mon_sel = 1'b0;
        chk_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Single frame of 0x00
        send(1'b0, vecs[0]);
        check_frame(1'b0, 1'b0, 1'b0, -1);
        @(negedge clk);
        chk_idle("after_00");
        @(negedge clk);

        // Back-to-back frames with tx_valid held high
        for (int i = 1; i <= 4; i++) begin
            send(1'b0, vecs[i]);
            check_frame(1'b0, (i < 4), 1'b0, -1);
            @(negedge clk);
            chk_idle("gap");
        end
        @(negedge clk);

        // tx_data change and tx_valid pulse mid-frame
        send(1'b0, vecs[5]);
        check_frame(1'b0, 1'b0, 1'b1, -1);
        quiet_ok = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (ser_a !== 1'b1 || ready_a !== 1'b1) quiet_ok = 1'b0;
        end
        chk("no_extra_frame", {31'd0, quiet_ok}, 32'd1);

        // Reset during data bit 3 of 0x55, then a clean resend
        send(1'b0, vecs[6]);
        check_frame(1'b0, 1'b0, 1'b0, 17);
        @(negedge clk);
        chk_idle("post_rst");
        send(1'b0, vecs[6]);
        check_frame(1'b0, 1'b0, 1'b0, -1);
        @(negedge clk);

        // One clock per bit instance
        send(1'b1, vecs[7]);
        check_frame(1'b1, 1'b0, 1'b0, -1);
        @(negedge clk);
        chk_idle("cpb1_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule : tb_odd_parity_serial_tx

// File: doc/odd_parity_serial_tx.md
Name: odd_parity_serial_tx

Overview:
- Serial frame transmitter that generates odd parity. It is the sending end for the team's odd-parity checker.
- Accepts a parallel word through a valid/ready handshake.
- Serialises the word LSB-first on a single line, framed as: start bit (0), DATA_W data bits, odd parity bit, stop bit (1).
- Sits between a parallel producer and the link that feeds the receive-side parity checker.

Parameters:
- DATA_W, 8: number of payload bits per frame (≥1).
- CLKS_PER_BIT, 4: clock cycles each serial bit is held on the line (≥1).

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- tx_valid  input  1  producer presents a word on tx_data.
- tx_data  input  DATA_W  word to transmit; sampled only on handshake.
- tx_ready  output  1  transmitter can accept a word (IDLE only).
- tx_serial  output  1  serial line; idles high; registered.
- tx_busy  output  1  a frame is in progress (any state other than IDLE).
- tx_done  output  1  one-cycle pulse in the final cycle of the stop bit.

Behaviour:
- Reset values (asynchronous on rst=1, held while rst=1):
  - tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0.
  - State = IDLE; all counters = 0.
- Parity rule: par = ~^tx_data. The number of 1s across data+par is always odd, so all-zero data gives par=1.
- Parity is computed from tx_data at acceptance and latched with the data into a shift register. Later changes to tx_data have no effect.
- Handshake: a word is accepted on a rising edge where tx_valid && tx_ready. tx_valid while busy is ignored, with no queuing.
- States and line levels:
  - IDLE: line=1; on accept, go to START.
  - START: line=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: line = shift[0]; shift right every CLKS_PER_BIT cycles. After DATA_W bits, go to PARITY.
  - PARITY: line = latched par for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: line=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Latency: accepted at edge k → tx_serial=0 from edge k (visible in cycle k+1).
- Frame length is exactly (DATA_W+3)*CLKS_PER_BIT cycles from first start-bit cycle to last stop-bit cycle.
- tx_done is high only in the last stop-bit cycle. tx_ready returns to 1 in the following cycle.
- Back-to-back frames: the minimum gap is 1 IDLE cycle (line high) between frames.
- Counters:
  - Baud counter width is $clog2(CLKS_PER_BIT), or 1 bit when CLKS_PER_BIT=1; it counts 0..CLKS_PER_BIT-1 and wraps.
  - Bit counter width is $clog2(DATA_W+1).
  - When CLKS_PER_BIT=1, each bit lasts exactly one cycle.
- Reset mid-frame: tx_serial goes to 1 immediately (no glitch to 0), the frame is abandoned, and the next accept starts a fresh frame.
- tx_valid asserted in the same cycle tx_done=1 is not accepted. It is accepted on the next edge if still asserted.

Decomposition:
- Package odd_parity_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - constants LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1.
- Sub-module odd_parity_gen (parameter DATA_W): combinational par = ~^data. It is shared with future checker refactors.

Test Plan (DATA_W=8, CLKS_PER_BIT=4):
- Send 0x00 → line reads 0, 00000000, par=1, 1; 44 cycles; tx_done pulses once at cycle 44.
- Send 0x01, 0x07, 0xA5, 0xFF back-to-back with tx_valid held high → par bits 0, 0, 1, 1; exactly 1 idle-high cycle between frames.
- Change tx_data mid-frame and assert tx_valid during DATA → frame unchanged, no extra frame, tx_ready=0 throughout.
- Assert rst during DATA bit 3 of 0x55 → tx_serial=1 immediately and busy=0; next send of 0x55 → full correct frame, par=1.
- CLKS_PER_BIT=1, send 0x80 → 11-cycle frame: 0, 00000001, 0, 1.
- Scoreboard: feed the captured data+par into the receive-side odd-parity checker; every frame must show an odd count of 1s.
